read_bram_ctrl: RTL

READ_BRAM_CTRL -- requirements
Module: read_bram_ctrl

---
 rtl/read_bram_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/read_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : read_bram_ctrl
// Brief    : Reads one tile of BRAM words per start_read and hands each word
//            to the systolic array with a valid/ready handshake.
//            Define BRAM_OUT_REG_EN when the BRAM output register is enabled
//            (read latency 2, adds a WAIT state).
// Revision : 1.0 - initial release
// ============================================================================
module read_bram_ctrl #(
  parameter int DATA_W         = 256,
  parameter int ADDR_W         = 16,
  parameter int STRIDE         = 23,
  parameter int WORDS_PER_TILE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_read,
  input  logic              reset_addr_counter,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic [DATA_W-1:0] sa_in_data,
  output logic              sa_in_valid,
  input  logic              sa_in_ready,
  output logic              read_done,
  output logic              busy,
  output logic [ADDR_W-1:0] current_addr
);

  localparam int                c_CNT_W  = $clog2(WORDS_PER_TILE + 1);
  localparam logic [ADDR_W-1:0] c_STRIDE = ADDR_W'(STRIDE);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WORDS_PER_TILE);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3,
    S_DONE    = 3'd4
`ifdef BRAM_OUT_REG_EN
    ,
    S_WAIT    = 3'd5
`endif
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_word_cnt;
  logic [ADDR_W-1:0]  w_next_addr;
  logic [c_CNT_W-1:0] w_next_cnt;

  // Address arithmetic wraps naturally at ADDR_W bits
  assign w_next_addr = current_addr + c_STRIDE;
  assign w_next_cnt  = r_word_cnt + c_CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_word_cnt   <= '0;
      enb          <= 1'b0;
      addrb        <= '0;
      sa_in_data   <= '0;
      sa_in_valid  <= 1'b0;
      read_done    <= 1'b0;
      busy         <= 1'b0;
      current_addr <= '0;
    end else begin
      enb       <= 1'b0;
      read_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (reset_addr_counter) begin
            current_addr <= '0;
          end
          if (start_read) begin
            r_state    <= S_ISSUE;
            r_word_cnt <= '0;
            busy       <= 1'b1;
            enb        <= 1'b1;
            addrb      <= reset_addr_counter ? '0 : current_addr;
          end
        end
        S_ISSUE: begin
`ifdef BRAM_OUT_REG_EN
          r_state <= S_WAIT;
`else
          r_state <= S_CAPTURE;
`endif
        end
`ifdef BRAM_OUT_REG_EN
        S_WAIT: begin
          r_state <= S_CAPTURE;
        end
`endif
        S_CAPTURE: begin
          sa_in_data  <= doutb;
          sa_in_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (sa_in_ready) begin
            sa_in_valid  <= 1'b0;
            current_addr <= w_next_addr;
            r_word_cnt   <= w_next_cnt;
            if (w_next_cnt == c_LAST) begin
              r_state   <= S_DONE;
              read_done <= 1'b1;
            end else begin
              // Next word of the tile is issued straight from the transfer cycle
              r_state <= S_ISSUE;
              enb     <= 1'b1;
              addrb   <= w_next_addr;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          busy        <= 1'b0;
          sa_in_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
